if_fetch: RTL and testbench

//   Instruction-fetch stage feeding id_decode (pc/inst). Owns the fetch PC and issues

---
 rtl/if_fetch.sv | 152 +++++++++++++++
 tb/tb_if_fetch.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding imem req/ack at a time,
// buffers returned words in a DEPTH-entry FIFO toward ID. Redirect/flush enabled by IF_FETCH_REDIRECT_EN.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        if_fetch_imem_req_o,
    output logic [31:0] if_fetch_imem_addr_o,
    input  logic        if_fetch_imem_ack_i,
    input  logic [31:0] if_fetch_imem_data_i,
    input  logic        if_fetch_stall_i,
    output logic        if_fetch_valid_o,
    output logic [31:0] if_fetch_pc_o,
    output logic [31:0] if_fetch_inst_o
`ifdef IF_FETCH_REDIRECT_EN
    ,
    input  logic        if_fetch_redirect_i,
    input  logic [31:0] if_fetch_redirect_pc_i
`endif
);

    // state  | meaning
    // S_IDLE | no request outstanding, waiting for a free buffer slot
    // S_REQ  | request to fetch_pc outstanding, word is kept on ack
    // S_DROP | stale request outstanding after a redirect, word is discarded on ack

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ
`ifdef IF_FETCH_REDIRECT_EN
        ,
        S_DROP
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     addr_q, addr_d;
    logic            req_q, req_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pc_mem_q   [DEPTH];
    logic [31:0]     inst_mem_q [DEPTH];

    logic            valid;
    logic            push;
    logic            pop;
    logic            flush;

    assign valid = (count_q != '0);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        pop        = valid && !if_fetch_stall_i;
        flush      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q < CW'(DEPTH)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (if_fetch_imem_ack_i) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if ((count_q + CW'(1) - CW'(pop)) >= CW'(DEPTH)) begin
                        state_d = S_IDLE;
                    end
                end
            end
`ifdef IF_FETCH_REDIRECT_EN
            S_DROP: begin
                if (if_fetch_imem_ack_i) begin
                    state_d = S_REQ;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef IF_FETCH_REDIRECT_EN
        // A redirect overrides everything: the buffer is flushed and the in-flight word, if any, becomes stale.
        if (if_fetch_redirect_i) begin
            flush      = 1'b1;
            push       = 1'b0;
            pop        = 1'b0;
            fetch_pc_d = {if_fetch_redirect_pc_i[31:2], 2'b00};
            if ((state_q == S_REQ || state_q == S_DROP) && !if_fetch_imem_ack_i) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end
`endif

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        // Address must stay put while a request is waiting for its ack.
        addr_d = (req_q && !if_fetch_imem_ack_i) ? addr_q : fetch_pc_d;
        req_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            inst_mem_q[wr_ptr_q] <= if_fetch_imem_data_i;
        end
    end

    assign if_fetch_imem_req_o  = req_q;
    assign if_fetch_imem_addr_o = addr_q;
    assign if_fetch_valid_o     = valid;
    assign if_fetch_pc_o        = valid ? pc_mem_q[rd_ptr_q] : 32'h0;
    assign if_fetch_inst_o      = valid ? inst_mem_q[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: randomized memory latency/stall against a sequential-PC model,
// plus a second instance at a wrapping RESET_PC. Redirect checks compile with IF_FETCH_REDIRECT_EN.
module tb_if_fetch;
    localparam int          DEPTH   = 2;
    localparam logic [31:0] KEY     = 32'hA5A5_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        req, ack, stall, valid;
    logic [31:0] addr, data, pc, inst;
`ifdef IF_FETCH_REDIRECT_EN
    logic        redirect;
    logic [31:0] redirect_pc;
`endif

    logic        req_w, valid_w, ack_w;
    logic [31:0] addr_w, data_w, pc_w, inst_w;
    assign ack_w  = req_w;
    assign data_w = addr_w ^ KEY;

    if_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
        .clk                   (clk),
        .rst                   (rst),
        .if_fetch_imem_req_o   (req),
        .if_fetch_imem_addr_o  (addr),
        .if_fetch_imem_ack_i   (ack),
        .if_fetch_imem_data_i  (data),
        .if_fetch_stall_i      (stall),
        .if_fetch_valid_o      (valid),
        .if_fetch_pc_o         (pc),
        .if_fetch_inst_o       (inst)
`ifdef IF_FETCH_REDIRECT_EN
        ,
        .if_fetch_redirect_i   (redirect),
        .if_fetch_redirect_pc_i(redirect_pc)
`endif
    );

    if_fetch #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) u_dut_w (
        .clk                   (clk),
        .rst                   (rst),
        .if_fetch_imem_req_o   (req_w),
        .if_fetch_imem_addr_o  (addr_w),
        .if_fetch_imem_ack_i   (ack_w),
        .if_fetch_imem_data_i  (data_w),
        .if_fetch_stall_i      (1'b0),
        .if_fetch_valid_o      (valid_w),
        .if_fetch_pc_o         (pc_w),
        .if_fetch_inst_o       (inst_w)
`ifdef IF_FETCH_REDIRECT_EN
        ,
        .if_fetch_redirect_i   (1'b0),
        .if_fetch_redirect_pc_i(32'h0)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    int          cmp_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;

    logic [31:0] model_pc = 32'h0;
    bit          pending = 1'b0;
    bit          stale = 1'b0;
    int          wcnt = 0;
    logic [31:0] req_addr = 32'h0;
    int          lat_mode = 0;
    logic [31:0] hold_addr = 32'hFFFF_FFFF;
    bit          spur_en = 1'b0;
    bit          redir_now = 1'b0;
    int          ack_total = 0;
    int          pop_total = 0;
    int          first_ack_cyc = -1;
    int          first_valid_cyc = -1;
    logic [31:0] last_pop_pc = 32'h0;
    logic [31:0] wexp = WRAP_PC;
    int          wn = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: acks after a chosen latency and records the expected delivery.
    initial begin
        ack  = 1'b0;
        data = 32'h0;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            if (!rst) begin
                pending = 1'b0;
                stale   = 1'b0;
            end else if (req) begin
                if (!pending) begin
                    pending  = 1'b1;
                    req_addr = addr;
                    wcnt     = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
                    check("req_addr", addr, model_pc);
                end else begin
                    check("addr_stable", addr, req_addr);
                end
                if (wcnt > 0) begin
                    wcnt--;
                end else if (addr < hold_addr) begin
                    ack     = 1'b1;
                    data    = addr ^ KEY;
                    pending = 1'b0;
                    ack_total++;
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        if (first_ack_cyc < 0) first_ack_cyc = cyc;
                        sb.push_back('{pc: model_pc, inst: model_pc ^ KEY});
                        model_pc = model_pc + 32'd4;
                    end
                end
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                ack  = 1'b1;
                data = $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard whenever ID takes the head.
    initial begin
        bit          held = 1'b0;
        logic [31:0] held_pc = 32'h0;
        logic [31:0] held_inst = 32'h0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                held = 1'b0;
            end else begin
                if (valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (valid && held) begin
                    check("stall_hold_pc", pc, held_pc);
                    check("stall_hold_inst", inst, held_inst);
                end
                if (!valid) begin
                    check("empty_pc_zero", pc, 32'h0);
                    check("empty_inst_zero", inst, 32'h0);
                end
                held      = valid && stall && !redir_now;
                held_pc   = pc;
                held_inst = inst;
                if (valid && !stall && !redir_now) begin
                    if (sb.size() == 0) begin
                        cmp_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_pop: pc %h delivered, expected no entry", pc);
                    end else begin
                        e = sb.pop_front();
                        check("pc", pc, e.pc);
                        check("inst", inst, e.inst);
                    end
                    pop_total++;
                    last_pop_pc = pc;
                end
            end
        end
    end

    // Wrap-around instance: first three delivered pcs after each reset.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                wexp = WRAP_PC;
                wn   = 0;
            end else if (valid_w && wn < 3) begin
                check("wrap_pc", pc_w, wexp);
                check("wrap_inst", inst_w, wexp ^ KEY);
                wexp = wexp + 32'd4;
                wn++;
            end
        end
    end

    initial begin
        #(10 * 20000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic assert_rst();
        rst = 1'b0;
        sb.delete();
        model_pc        = 32'h0;
        pending         = 1'b0;
        stale           = 1'b0;
        first_ack_cyc   = -1;
        first_valid_cyc = -1;
    endtask

    task automatic do_reset();
        step();
        assert_rst();
        repeat (2) step();
        rst = 1'b1;
    endtask

    initial begin
        int a0, p0, occ, i;
        bit found;
        stall = 1'b0;
`ifdef IF_FETCH_REDIRECT_EN
        redirect    = 1'b0;
        redirect_pc = 32'h0;
`endif
        assert_rst();
        repeat (3) step();

        check("rst_req", {31'h0, req}, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_addr_wrap", addr_w, WRAP_PC);

        // 0-wait memory, no stall: one instruction per cycle after one-cycle latency.
        lat_mode = 0;
        rst = 1'b1;
        for (i = 0; i < 20 && !valid; i++) step();
        check("first_valid_seen", {31'h0, valid}, 32'h1);
        p0 = pop_total;
        repeat (16) step();
        check("throughput_0wait", 32'(pop_total - p0), 32'd16);
        check("first_valid_latency", 32'(first_valid_cyc), 32'(first_ack_cyc + 1));

        // Stall fills the buffer, then requests stop.
        occ   = sb.size();
        a0    = ack_total;
        stall = 1'b1;
        repeat (10) step();
        check("stall_acks", 32'(ack_total - a0), 32'(DEPTH - occ));
        check("full_req_low", {31'h0, req}, 32'h0);
        check("full_valid", {31'h0, valid}, 32'h1);
        check("full_depth", 32'(sb.size()), 32'(DEPTH));
        stall = 1'b0;
        repeat (20) step();

        // Fixed 3-cycle ack latency.
        lat_mode = 3;
        repeat (12) step();
        a0 = ack_total;
        repeat (40) step();
        check("rate_lat3", 32'(ack_total - a0), 32'd10);

        // Random latency, stall and stray acks.
        lat_mode = -1;
        spur_en  = 1'b1;
        p0 = pop_total;
        repeat (400) begin
            step();
            stall = ($urandom_range(0, 9) < 3);
        end
        stall    = 1'b0;
        spur_en  = 1'b0;
        lat_mode = 0;
        check("random_progress", {31'h0, (pop_total - p0) >= 40}, 32'h1);
        repeat (10) step();

`ifdef IF_FETCH_REDIRECT_EN
        // Redirect while the request to 0x10 is waiting.
        hold_addr = 32'h10;
        do_reset();
        found = 1'b0;
        for (i = 0; i < 40 && !found; i++) begin
            step();
            found = req && addr == 32'h10;
        end
        check("wait_on_0x10", {31'h0, found}, 32'h1);
        repeat (2) step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        redir_now   = 1'b1;
        model_pc    = 32'h100;
        sb.delete();
        stale       = pending;
        step();
        redirect  = 1'b0;
        redir_now = 1'b0;
        hold_addr = 32'hFFFF_FFFF;
        check("flush_valid", {31'h0, valid}, 32'h0);
        check("drop_req_held", {31'h0, req}, 32'h1);
        check("drop_addr_held", addr, 32'h10);
        p0 = pop_total;
        for (i = 0; i < 20 && pop_total == p0; i++) step();
        check("redirect_first_pc", last_pop_pc, 32'h100);
        repeat (10) step();
`endif

        // Reset asserted while a request waits and the buffer holds a word.
        hold_addr = 32'h4;
        stall     = 1'b1;
        do_reset();
        found = 1'b0;
        for (i = 0; i < 20 && !found; i++) begin
            step();
            found = req && addr == 32'h4 && valid;
        end
        check("pending_before_rst", {31'h0, found}, 32'h1);
        #1;
        assert_rst();
        #1;
        check("async_rst_req", {31'h0, req}, 32'h0);
        check("async_rst_valid", {31'h0, valid}, 32'h0);
        step();
        stall     = 1'b0;
        hold_addr = 32'hFFFF_FFFF;
        rst       = 1'b1;
        found = 1'b0;
        for (i = 0; i < 10 && !found; i++) begin
            step();
            found = req;
        end
        check("post_rst_req", {31'h0, found}, 32'h1);
        check("post_rst_addr", addr, 32'h0);
        repeat (20) step();
        check("wrap_seen", 32'(wn), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
